// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default tuning constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_D = 2'd1,
    BUS_I = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam int DEFAULT_MAX_WAIT   = 15;
  localparam int DEFAULT_STARVE_LIM = 4;
  localparam int STARVE_SAT         = 7;

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// Counts bus wait cycles of the current grant and flags the cycle on which the wait limit is hit.
module arb_wait_timer
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);

  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (clear) begin
      wait_cnt <= '0;
    end else if (enable) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Fires on the wait cycle whose increment would bring wait_cnt to MAX_WAIT.
  assign timeout = enable && (wait_cnt == 8'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one shared memory bus,
// favouring data but bounding how long a pending fetch can be starved.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_WAIT   = DEFAULT_MAX_WAIT,
  parameter int STARVE_LIM = DEFAULT_STARVE_LIM
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              bus_valid,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_err
);

  localparam logic [2:0] STARVE_LIM_W = 3'(STARVE_LIM);
  localparam logic [2:0] STARVE_SAT_W = 3'(STARVE_SAT);

  arb_state_t        state;
  arb_state_t        next_state;
  logic [2:0]        starve_cnt;
  logic              grant_d;
  logic              err_flag;
  logic [DATA_W-1:0] data_q;
  logic              in_bus;
  logic              timeout;

  assign in_bus = (state == BUS_D) || (state == BUS_I);

  arb_wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == IDLE),
    .enable (in_bus && !bus_ready),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (d_req && !(if_req && (starve_cnt >= STARVE_LIM_W))) begin
          next_state = BUS_D;
        end else if (if_req) begin
          next_state = BUS_I;
        end
      end
      BUS_D, BUS_I: begin
        if (bus_ready || timeout) begin
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    d_ack    = (state == RESP) && grant_d;
    if_ack   = (state == RESP) && !grant_d;
    bus_err  = (state == RESP) && err_flag;
    d_rdata  = d_ack ? data_q : '0;
    if_rdata = if_ack ? data_q : '0;
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

  // Bus request, grant owner, starvation count and response data all move only on state transitions.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      grant_d    <= 1'b0;
      err_flag   <= 1'b0;
      starve_cnt <= '0;
      data_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          err_flag <= 1'b0;
          if (next_state == BUS_D) begin
            bus_valid <= 1'b1;
            bus_we    <= d_we;
            bus_addr  <= d_addr;
            bus_wdata <= d_wdata;
            grant_d   <= 1'b1;
            if (if_req && (starve_cnt != STARVE_SAT_W)) begin
              starve_cnt <= starve_cnt + 3'd1;
            end
          end else if (next_state == BUS_I) begin
            bus_valid  <= 1'b1;
            bus_we     <= 1'b0;
            bus_addr   <= if_addr;
            bus_wdata  <= '0;
            grant_d    <= 1'b0;
            starve_cnt <= '0;
          end
        end
        BUS_D, BUS_I: begin
          if (next_state == RESP) begin
            bus_valid <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            data_q    <= (bus_ready && !bus_we) ? bus_rdata : '0;
            err_flag  <= !bus_ready;
          end
        end
        RESP: begin
          data_q <= '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter: a per-cycle vector table plus
// hand-written sequences for starvation, timeout, timeout/ready race and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_err;

  int assert_count = 0;
  int fail_count   = 0;

  typedef struct {
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        if_req;
    logic [31:0] if_addr;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        exp_valid;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic        exp_d_ack;
    logic [31:0] exp_d_rdata;
    logic        exp_if_ack;
    logic [31:0] exp_if_rdata;
    logic        exp_stall_if;
    logic        exp_stall_mem;
  } vec_t;

  vec_t vecs[13];

  mem_port_arbiter dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ack   (if_ack),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ack    (d_ack),
    .bus_valid(bus_valid),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .bus_ready(bus_ready),
    .stall_if (stall_if),
    .stall_mem(stall_mem),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    d_req     = v.d_req;
    d_we      = v.d_we;
    d_addr    = v.d_addr;
    d_wdata   = v.d_wdata;
    if_req    = v.if_req;
    if_addr   = v.if_addr;
    bus_ready = v.bus_ready;
    bus_rdata = v.bus_rdata;
  endtask

  task automatic clearInputs();
    d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    if_req = 0; if_addr = '0; bus_ready = 0; bus_rdata = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    clearInputs();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  function automatic vec_t mkVec(
    input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dwd,
    input logic ir, input logic [31:0] ia, input logic rdy, input logic [31:0] rd,
    input logic ev, input logic ew, input logic [31:0] ea, input logic [31:0] ewd,
    input logic eda, input logic [31:0] edr, input logic eia, input logic [31:0] eir,
    input logic esi, input logic esm);
    vec_t v;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dwd;
    v.if_req = ir; v.if_addr = ia; v.bus_ready = rdy; v.bus_rdata = rd;
    v.exp_valid = ev; v.exp_we = ew; v.exp_addr = ea; v.exp_wdata = ewd;
    v.exp_d_ack = eda; v.exp_d_rdata = edr; v.exp_if_ack = eia; v.exp_if_rdata = eir;
    v.exp_stall_if = esi; v.exp_stall_mem = esm;
    return v;
  endfunction

  initial begin
    logic [7:0] grants[6];
    logic [7:0] exp_grants[6];
    int n;
    int valid_cycles;

    clearInputs();
    reset = 1'b0;

    // Load 0x100 (ready on 2nd bus cycle), store 0x40, then a fetch of 0x200.
    vecs[0]  = mkVec(1,0,32'h100,0,          0,0,0,0,            0,0,0,0,                   0,0,0,0, 0,1);
    vecs[1]  = mkVec(1,0,32'h100,0,          0,0,0,0,            1,0,32'h100,0,             0,0,0,0, 0,1);
    vecs[2]  = mkVec(1,0,32'h100,0,          0,0,1,32'hDEADBEEF, 1,0,32'h100,0,             0,0,0,0, 0,1);
    vecs[3]  = mkVec(1,0,32'h100,0,          0,0,0,0,            0,0,0,0,                   1,32'hDEADBEEF,0,0, 0,0);
    vecs[4]  = mkVec(1,1,32'h40,32'h12345678,0,0,0,0,            0,0,0,0,                   0,0,0,0, 0,1);
    vecs[5]  = mkVec(1,1,32'h40,32'h12345678,0,0,0,0,            1,1,32'h40,32'h12345678,   0,0,0,0, 0,1);
    vecs[6]  = mkVec(1,1,32'h40,32'h12345678,0,0,1,32'hCAFEF00D, 1,1,32'h40,32'h12345678,   0,0,0,0, 0,1);
    vecs[7]  = mkVec(1,1,32'h40,32'h12345678,0,0,0,0,            0,0,0,0,                   1,0,0,0, 0,0);
    vecs[8]  = mkVec(0,0,0,0,                0,0,0,0,            0,0,0,0,                   0,0,0,0, 0,0);
    vecs[9]  = mkVec(0,0,0,0,                1,32'h200,0,0,      0,0,0,0,                   0,0,0,0, 1,0);
    vecs[10] = mkVec(0,0,0,0,                1,32'h200,1,32'h0BADC0DE, 1,0,32'h200,0,       0,0,0,0, 1,0);
    vecs[11] = mkVec(0,0,0,0,                1,32'h200,0,0,      0,0,0,0,                   0,0,1,32'h0BADC0DE, 0,0);
    vecs[12] = mkVec(0,0,0,0,                0,0,0,0,            0,0,0,0,                   0,0,0,0, 0,0);

    repeat (2) @(negedge clk);
    checkOutput("reset_bus_valid", 32'(bus_valid), 32'd0);
    checkOutput("reset_d_ack",     32'(d_ack),     32'd0);
    checkOutput("reset_if_ack",    32'(if_ack),    32'd0);
    checkOutput("reset_bus_err",   32'(bus_err),   32'd0);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_bus_valid", i), 32'(bus_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        checkOutput($sformatf("v%0d_bus_we", i),    32'(bus_we), 32'(vecs[i].exp_we));
        checkOutput($sformatf("v%0d_bus_addr", i),  bus_addr,    vecs[i].exp_addr);
        checkOutput($sformatf("v%0d_bus_wdata", i), bus_wdata,   vecs[i].exp_wdata);
      end
      checkOutput($sformatf("v%0d_d_ack", i),     32'(d_ack),     32'(vecs[i].exp_d_ack));
      checkOutput($sformatf("v%0d_d_rdata", i),   d_rdata,        vecs[i].exp_d_rdata);
      checkOutput($sformatf("v%0d_if_ack", i),    32'(if_ack),    32'(vecs[i].exp_if_ack));
      checkOutput($sformatf("v%0d_if_rdata", i),  if_rdata,       vecs[i].exp_if_rdata);
      checkOutput($sformatf("v%0d_stall_if", i),  32'(stall_if),  32'(vecs[i].exp_stall_if));
      checkOutput($sformatf("v%0d_stall_mem", i), 32'(stall_mem), 32'(vecs[i].exp_stall_mem));
      checkOutput($sformatf("v%0d_bus_err", i),   32'(bus_err),   32'd0);
    end

    // Both ports held with an always-ready bus: fetch wins on the 5th grant.
    doReset();
    d_req = 1; d_addr = 32'h600; if_req = 1; if_addr = 32'h700;
    bus_ready = 1; bus_rdata = 32'h11112222;
    exp_grants = '{"D", "D", "D", "D", "I", "D"};
    n = 0;
    for (int k = 0; k < 40 && n < 6; k++) begin
      @(negedge clk);
      if (d_ack)  begin grants[n] = "D"; n++; end
      else if (if_ack) begin grants[n] = "I"; n++; end
    end
    checkOutput("starve_grant_count", 32'(n), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < n) checkOutput($sformatf("starve_grant_%0d", k), 32'(grants[k]), 32'(exp_grants[k]));
    end

    // Fetch on a bus that never answers times out after 15 wait cycles.
    doReset();
    if_req = 1; if_addr = 32'h300; bus_rdata = 32'hFFFFFFFF;
    valid_cycles = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus_valid) valid_cycles++;
      else if (valid_cycles > 0) break;
    end
    checkOutput("timeout_valid_cycles", 32'(valid_cycles), 32'd15);
    checkOutput("timeout_if_ack",   32'(if_ack),  32'd1);
    checkOutput("timeout_bus_err",  32'(bus_err), 32'd1);
    checkOutput("timeout_if_rdata", if_rdata,     32'd0);
    if_req = 0;
    @(negedge clk);
    checkOutput("timeout_err_pulse", 32'(bus_err), 32'd0);
    checkOutput("timeout_ack_pulse", 32'(if_ack),  32'd0);

    // Ready arrives on the very cycle the timeout would fire.
    doReset();
    if_req = 1; if_addr = 32'h304;
    valid_cycles = 0;
    for (int k = 0; k < 40 && valid_cycles < 15; k++) begin
      @(negedge clk);
      if (bus_valid) valid_cycles++;
    end
    checkOutput("race_valid_cycles", 32'(valid_cycles), 32'd15);
    bus_ready = 1; bus_rdata = 32'hA5A55A5A;
    @(negedge clk);
    bus_ready = 0; if_req = 0;
    checkOutput("race_if_ack",   32'(if_ack),  32'd1);
    checkOutput("race_if_rdata", if_rdata,     32'hA5A55A5A);
    checkOutput("race_bus_err",  32'(bus_err), 32'd0);

    // Reset pulsed mid-BUS_D abandons the transaction; the held request is re-granted.
    doReset();
    d_req = 1; d_addr = 32'h500;
    @(negedge clk);
    checkOutput("rst_pre_valid", 32'(bus_valid), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("rst_async_valid", 32'(bus_valid), 32'd0);
    @(negedge clk);
    checkOutput("rst_hold_d_ack_a", 32'(d_ack), 32'd0);
    @(negedge clk);
    checkOutput("rst_hold_d_ack_b", 32'(d_ack), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst_regrant_valid", 32'(bus_valid), 32'd1);
    checkOutput("rst_regrant_addr",  bus_addr,       32'h500);
    checkOutput("rst_regrant_d_ack", 32'(d_ack),     32'd0);
    bus_ready = 1; bus_rdata = 32'h00000077;
    @(negedge clk);
    bus_ready = 0; d_req = 0;
    checkOutput("rst_final_d_ack",   32'(d_ack), 32'd1);
    checkOutput("rst_final_d_rdata", d_rdata,    32'h00000077);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
